// File: rtl/wb_burst_master_pkg.sv
// Shared definitions for the Wishbone burst master.
// Contents: FSM state encoding, CTI/BTE codes and a helper that normalises the
// requested burst length into the range 1..max_len.
package wb_burst_master_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StBackoff,
    StFinish
  } state_e;

  localparam logic [2:0] CtiClassic = 3'b000;
  localparam logic [2:0] CtiIncr    = 3'b010;
  localparam logic [2:0] CtiEob     = 3'b111;
  localparam logic [1:0] BteLinear  = 2'b00;

  // Zero-length requests run one beat; oversized requests are clamped.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/wb_burst_master_watchdog.sv
// Response watchdog for the Wishbone burst master.
// Counts cycles in which a beat is presented (run=1) without any slave
// response; flags expiry on the TIMEOUT-th silent cycle.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   run       strobe is high in the active state
//   resp      ack, err or rty seen this cycle (clears the count)
//   expired   combinational: this is the TIMEOUT-th silent cycle
module wb_burst_master_watchdog #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic resp,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  assign expired = run & ~resp & (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!run || resp || expired) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 master issuing single or incrementing-burst transfers for a
// local requester, with bounded retry and an optional response watchdog.
// Build option: define WB_MASTER_TIMEOUT_EN to enable the watchdog (abort after
// TIMEOUT silent strobe cycles); otherwise the master waits indefinitely.
// Ports:
//   wb_clk, wb_rst        clock, asynchronous active-high reset
//   start                 request strobe, sampled only when idle
//   address/selection/write/burst_len  request attributes, latched on start
//   wr_data / wr_next     show-ahead write source and its advance pulse
//   rd_data / rd_valid    registered read word and one-cycle valid
//   active/done/error     busy flag, end-of-transfer pulse, abort qualifier
//   wb_*                  Wishbone B3 master interface
module wb_burst_master
  import wb_burst_master_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 32,
  parameter int unsigned SW        = DW / 8,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned RETRY_MAX = 3,
  parameter int unsigned TIMEOUT   = 256
) (
  input  logic                         wb_clk,
  input  logic                         wb_rst,
  input  logic                         start,
  input  logic [AW-1:0]                address,
  input  logic [SW-1:0]                selection,
  input  logic                         write,
  input  logic [$clog2(MAX_BURST):0]   burst_len,
  input  logic [DW-1:0]                wr_data,
  output logic                         wr_next,
  output logic [DW-1:0]                rd_data,
  output logic                         rd_valid,
  output logic                         active,
  output logic                         done,
  output logic                         error,
  output logic [AW-1:0]                wb_adr_o,
  output logic [DW-1:0]                wb_dat_o,
  output logic [SW-1:0]                wb_sel_o,
  output logic                         wb_we_o,
  output logic                         wb_cyc_o,
  output logic                         wb_stb_o,
  output logic [2:0]                   wb_cti_o,
  output logic [1:0]                   wb_bte_o,
  input  logic [DW-1:0]                wb_dat_i,
  input  logic                         wb_ack_i,
  input  logic                         wb_err_i,
  input  logic                         wb_rty_i
);

  localparam int unsigned LW = $clog2(MAX_BURST) + 1;
  // Wide enough to hold RETRY_MAX + 1, the count that triggers the abort.
  localparam int unsigned RW = $clog2(RETRY_MAX + 2);

  state_e          state_q, state_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            we_q, we_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   beat_q, beat_d;
  logic [RW-1:0]   rty_q, rty_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            err_q, err_d;
  logic            abort;
  logic            last_beat;
  logic            wd_expired;
  logic [RW-1:0]   rty_inc;

  assign last_beat = (beat_q == len_q - 1'b1);
  assign rty_inc   = rty_q + 1'b1;

`ifdef WB_MASTER_TIMEOUT_EN
  wb_burst_master_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (wb_clk),
    .rst    (wb_rst),
    .run    ((state_q == StActive) && stb_q),
    .resp   (wb_ack_i | wb_err_i | wb_rty_i),
    .expired(wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    sel_d      = sel_q;
    we_d       = we_q;
    len_d      = len_q;
    beat_d     = beat_q;
    rty_d      = rty_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = err_q;
    abort      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          adr_d   = address;
          sel_d   = selection;
          we_d    = write;
          len_d   = LW'(clamp_len(32'(burst_len), MAX_BURST));
          beat_d  = '0;
          rty_d   = '0;
          err_d   = 1'b0;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = StActive;
        end
      end
      StActive: begin
        // Response priority: err > rty > ack.
        if (wb_err_i) begin
          abort = 1'b1;
        end else if (wb_rty_i) begin
          rty_d = rty_inc;
          if (rty_inc > RW'(RETRY_MAX)) begin
            abort = 1'b1;
          end else begin
            stb_d   = 1'b0;
            state_d = StBackoff;
          end
        end else if (wb_ack_i) begin
          rty_d  = '0;
          beat_d = beat_q + 1'b1;
          adr_d  = adr_q + AW'(DW / 8);
          if (!we_q) begin
            rd_data_d  = wb_dat_i;
            rd_valid_d = 1'b1;
          end
          if (last_beat) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            state_d = StFinish;
          end
        end else if (wd_expired) begin
          abort = 1'b1;
        end
        if (abort) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          err_d   = 1'b1;
          state_d = StFinish;
        end
      end
      StBackoff: begin
        // Re-issue the same beat; address was not advanced by the retry.
        stb_d   = 1'b1;
        state_d = StActive;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q    <= StIdle;
      adr_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      len_q      <= '0;
      beat_q     <= '0;
      rty_q      <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      rty_q      <= rty_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    wb_cti_o = CtiClassic;
    if (cyc_q && (len_q != LW'(1))) begin
      wb_cti_o = last_beat ? CtiEob : CtiIncr;
    end
  end

  assign wb_adr_o = adr_q;
  assign wb_sel_o = cyc_q ? sel_q : '0;
  assign wb_we_o  = cyc_q & we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_bte_o = BteLinear;
  assign wb_dat_o = (we_q && stb_q) ? wr_data : '0;
  // A beat is accepted only when ack wins the response priority.
  assign wr_next  = (state_q == StActive) & stb_q & we_q & wb_ack_i & ~wb_err_i & ~wb_rty_i;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign active   = (state_q != StIdle);
  assign done     = (state_q == StFinish);
  assign error    = done & err_q;

endmodule

// File: tb/tb_wb_burst_master.sv
// Self-checking bench for wb_burst_master: table of transactions plus hand
// sequences for reset mid-burst and the silent-slave case.
module tb_wb_burst_master;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned LW = 5;

  logic          wb_clk = 1'b0;
  logic          wb_rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] address = '0;
  logic [SW-1:0] selection = '0;
  logic          write = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic [DW-1:0] wr_data;
  logic          wr_next;
  logic [DW-1:0] rd_data;
  logic          rd_valid, active, done, error;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel_o;
  logic          wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]    wb_cti_o;
  logic [1:0]    wb_bte_o;
  logic [DW-1:0] wb_dat_i = '0;
  logic          wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;

  always #5 wb_clk = ~wb_clk;

  wb_burst_master #(
    .DW(DW), .AW(AW), .SW(SW), .MAX_BURST(16), .RETRY_MAX(3), .TIMEOUT(8)
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .start(start), .address(address),
    .selection(selection), .write(write), .burst_len(burst_len), .wr_data(wr_data),
    .wr_next(wr_next), .rd_data(rd_data), .rd_valid(rd_valid), .active(active),
    .done(done), .error(error), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  // Script chars, one per strobe cycle: W wait, A ack, R retry, E err, B err+ack.
  typedef struct packed {
    logic          we;
    logic [AW-1:0] adr;
    logic [LW-1:0] len;
    logic [SW-1:0] sel;
    logic [95:0]   script;
    logic [7:0]    dflt;
    logic          exp_err;
    logic [7:0]    left;
  } txn_t;

  typedef struct packed {
    logic [AW-1:0] adr;
    logic [2:0]    cti;
  } beat_t;

  txn_t          tbl [10];
  beat_t         exp_beats[$];
  logic [DW-1:0] exp_rd[$];
  byte           script_q[$];
  byte           dflt_code = "W";
  logic          cur_we = 1'b0;
  logic [SW-1:0] cur_sel = '0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            widx = 0;
  bit            adv = 1'b0;
  bit            prev_rty = 1'b0;
  int            stb_cycles = 0;
  int            rcnt = 0;

  function automatic logic [DW-1:0] wpat(input int i);
    return 32'hA5A5_0000 + 32'(i) * 32'h0101;
  endfunction

  function automatic txn_t mk(input bit we, input logic [AW-1:0] adr, input logic [LW-1:0] len,
                              input logic [SW-1:0] sel, input logic [95:0] script,
                              input logic [7:0] dflt, input bit exp_err, input logic [7:0] left);
    txn_t t;
    t.we = we; t.adr = adr; t.len = len; t.sel = sel; t.script = script;
    t.dflt = dflt; t.exp_err = exp_err; t.left = left;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave model and scoreboard.
  initial begin : slave
    byte           code;
    beat_t         b;
    logic [DW-1:0] exp_dat;
    wr_data = wpat(0);
    forever begin
      @(posedge wb_clk);
      if (adv) begin
        widx++;
        wr_data = wpat(widx);
        adv = 1'b0;
      end
      @(negedge wb_clk);
      if (rd_valid) begin
        if (exp_rd.size() == 0) check("rd_valid_unexpected", 1, 0);
        else check("rd_data", rd_data, exp_rd.pop_front());
      end
      if (prev_rty) check("stb_low_after_rty", wb_stb_o, 0);
      prev_rty = 1'b0;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
      if (wb_cyc_o && wb_stb_o) begin
        stb_cycles++;
        if (script_q.size() != 0) code = script_q.pop_front();
        else code = dflt_code;
        if (exp_beats.size() == 0) begin
          check("beat_unexpected", 1, 0);
        end else begin
          b = exp_beats[0];
          check("adr", wb_adr_o, b.adr);
          check("cti", wb_cti_o, b.cti);
        end
        check("we", wb_we_o, cur_we);
        check("sel", wb_sel_o, cur_sel);
        check("bte", wb_bte_o, 0);
        exp_dat = cur_we ? wpat(widx) : '0;
        check("dat_o", wb_dat_o, exp_dat);
        case (code)
          "A": begin
            wb_ack_i = 1'b1;
            if (!cur_we) begin
              wb_dat_i = 32'hD00D_0000 + 32'(rcnt);
              rcnt++;
              exp_rd.push_back(wb_dat_i);
            end
          end
          "R": begin wb_rty_i = 1'b1; prev_rty = 1'b1; end
          "E": wb_err_i = 1'b1;
          "B": begin wb_err_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'hBAD0_0000; end
          default: ;
        endcase
        #1;
        check("wr_next", wr_next, cur_we && (code == "A"));
        if (code == "A" && exp_beats.size() != 0) begin
          void'(exp_beats.pop_front());
          if (cur_we) adv = 1'b1;
        end
      end
    end
  end

  task automatic launch(input txn_t t);
    int  n;
    byte c;
    beat_t b;
    @(negedge wb_clk);
    check("idle_before_start", active, 0);
    check("done_low_idle", done, 0);
    n = (t.len == 0) ? 1 : ((t.len > 16) ? 16 : int'(t.len));
    for (int i = 0; i < n; i++) begin
      b.adr = t.adr + 32'(4 * i);
      b.cti = (n == 1) ? 3'b000 : ((i == n - 1) ? 3'b111 : 3'b010);
      exp_beats.push_back(b);
    end
    script_q.delete();
    for (int i = 11; i >= 0; i--) begin
      c = t.script[8*i +: 8];
      if (c != 0) script_q.push_back(c);
    end
    dflt_code = t.dflt;
    cur_we = t.we;
    cur_sel = t.sel;
    start = 1'b1; address = t.adr; selection = t.sel; write = t.we; burst_len = t.len;
    @(negedge wb_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input bit exp_err, input int left);
    bit seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge wb_clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", seen, 1);
    if (seen) begin
      #2;
      check("error", error, exp_err);
      check("cyc_at_done", wb_cyc_o, 0);
      check("beats_left", exp_beats.size(), left);
      if (!exp_err) check("rd_left", exp_rd.size(), 0);
    end
    exp_beats.delete();
    exp_rd.delete();
    script_q.delete();
  endtask

  task automatic run_txn(input txn_t t);
    launch(t);
    wait_done(t.exp_err, int'(t.left));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

  initial begin : main
    txn_t t;
    int   base;
    tbl[0] = mk(0, 32'h0000_0100, 1,  4'hF, "WWA",    "A", 0, 0);
    tbl[1] = mk(1, 32'h0000_1000, 4,  4'hF, "AAAA",   "A", 0, 0);
    tbl[2] = mk(0, 32'h0000_2000, 4,  4'h3, "ARRAAA", "A", 0, 0);
    tbl[3] = mk(0, 32'h0000_3000, 2,  4'hF, "RRRR",   "A", 1, 2);
    tbl[4] = mk(0, 32'h0000_4000, 3,  4'hF, "AB",     "A", 1, 2);
    tbl[5] = mk(1, 32'h0000_5000, 0,  4'h1, "A",      "A", 0, 0);
    tbl[6] = mk(1, 32'h0000_6000, 20, 4'hF, "",       "A", 0, 0);
    tbl[7] = mk(0, 32'hFFFF_FFFC, 2,  4'hC, "WA",     "A", 0, 0);
    tbl[8] = mk(1, 32'h0000_7000, 3,  4'hF, "E",      "A", 1, 3);
    tbl[9] = mk(0, 32'h0000_8000, 2,  4'hF, "RRRA",   "A", 0, 0);

    repeat (3) @(negedge wb_clk);
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_cti", wb_cti_o, 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_we", wb_we_o, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_wr_next", wr_next, 0);
    check("rst_active", active, 0);
    #3 wb_rst = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    // Reset while beat 3 of a write burst is on the bus.
    t = mk(1, 32'h0000_9000, 8, 4'hF, "AA", "W", 0, 0);
    launch(t);
    for (int i = 0; i < 50 && exp_beats.size() > 6; i++) @(negedge wb_clk);
    check("rst_reached_beat3", exp_beats.size(), 6);
    @(negedge wb_clk);
    #3 wb_rst = 1'b1;
    #1;
    check("midrst_cyc", wb_cyc_o, 0);
    check("midrst_stb", wb_stb_o, 0);
    check("midrst_active", active, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk);
      check("midrst_no_done", done, 0);
    end
    #3 wb_rst = 1'b0;
    exp_beats.delete();
    exp_rd.delete();
    script_q.delete();
    run_txn(tbl[1]);

    // Silent slave.
    t = mk(0, 32'h0000_A000, 1, 4'hF, "", "W", 0, 0);
    base = stb_cycles;
    launch(t);
`ifdef WB_MASTER_TIMEOUT_EN
    wait_done(1, 1);
    check("timeout_cycles", stb_cycles - base, 8);
`else
    repeat (40) @(negedge wb_clk);
    check("silent_no_done", done, 0);
    check("silent_active", active, 1);
    check("silent_cyc", wb_cyc_o, 1);
    check("silent_stb", wb_stb_o, 1);
    dflt_code = "A";
    wait_done(0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
